dec_issue_queue: RTL and testbench

- Dual-issue instruction buffer and dispatch controller sitting between fetch and the instruction decoder.
- Accepts up to two fetched instruction/PC pairs per cycle and buffers them in order.
- Presents up to two in-order instructions per cycle on the decoder's slot-1/slot-2 inputs, throttled by ROB free space and jump serialization.
- Clears on pipeline flush.

---
 rtl/dec_issue_queue.sv | 158 +++++++++++++++
 tb/tb_dec_issue_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_issue_queue.sv
// Dual-issue in-order instruction buffer between fetch and decode, with ROB/jump-throttled dispatch.
// Optional ROB stall counter enabled by defining DEC_STALL_CNT_EN.
module dec_issue_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int OP_WIDTH    = 7,
  parameter int DEPTH       = 8,
  localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_valid1_i,
  input  logic [INSTR_WIDTH-1:0] fetch_instr1_i,
  input  logic [PC_WIDTH-1:0]    fetch_pc1_i,
  input  logic                   fetch_valid2_i,
  input  logic [INSTR_WIDTH-1:0] fetch_instr2_i,
  input  logic [PC_WIDTH-1:0]    fetch_pc2_i,
  output logic                   fetch_ready_o,
  input  logic [1:0]             rob_free_i,
  input  logic                   flush_i,
  output logic [INSTR_WIDTH-1:0] instruction1_o,
  output logic                   ins1_valid_o,
  output logic [PC_WIDTH-1:0]    PC1_o,
  output logic [INSTR_WIDTH-1:0] instruction2_o,
  output logic                   ins2_valid_o,
  output logic [PC_WIDTH-1:0]    PC2_o,
  output logic [CNT_WIDTH-1:0]   occupancy_o,
  output logic                   overflow_err_o,
  output logic [31:0]            stall_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [OP_WIDTH-1:0] JUMP_OP = OP_WIDTH'(7'b1100111);

  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic [PC_WIDTH-1:0]    pc_q    [DEPTH];

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic [1:0]          rob_sat_s;
  logic [1:0]          disp_n_s;
  logic [1:0]          push_n_s;
  logic [OP_WIDTH-1:0] head_op_s;
  logic [PTR_W-1:0]    head1_s;
  logic [PTR_W-1:0]    wr2_idx_s;
  logic                ready_s;
  logic                accept_s;
  logic                wr1_s;
  logic                wr2_s;
  logic                any_push_s;

  assign head1_s   = head_q + PTR_W'(1);
  assign head_op_s = instr_q[head_q][OP_WIDTH-1:0];
  // Ready uses only the registered count; same-cycle pops are not credited.
  assign ready_s   = (count_q <= CNT_WIDTH'(DEPTH - 2));

  assign any_push_s = fetch_valid1_i | fetch_valid2_i;
  assign accept_s   = ready_s & ~flush_i & ~rst;
  assign wr1_s      = accept_s & fetch_valid1_i;
  assign wr2_s      = accept_s & fetch_valid2_i;
  assign wr2_idx_s  = fetch_valid1_i ? (tail_q + PTR_W'(1)) : tail_q;
  assign push_n_s   = {1'b0, wr1_s} + {1'b0, wr2_s};

  // Dispatch count: limited by occupancy, ROB space, and jump serialization at the head.
  always_comb begin
    rob_sat_s = (rob_free_i == 2'd3) ? 2'd2 : rob_free_i;
    disp_n_s  = 2'd0;
    if (rst || flush_i) begin
      disp_n_s = 2'd0;
    end else if (count_q == CNT_WIDTH'(0) || rob_sat_s == 2'd0) begin
      disp_n_s = 2'd0;
    end else if (count_q == CNT_WIDTH'(1) || rob_sat_s == 2'd1 || head_op_s == JUMP_OP) begin
      disp_n_s = 2'd1;
    end else begin
      disp_n_s = 2'd2;
    end
  end

  // Pointer, count and sticky-error next state; flush re-aligns head onto tail.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = CNT_WIDTH'(0);
    end else begin
      head_d  = head_q + PTR_W'(disp_n_s);
      tail_d  = tail_q + PTR_W'(push_n_s);
      count_d = count_q + CNT_WIDTH'(push_n_s) - CNT_WIDTH'(disp_n_s);
    end
    if (any_push_s && !ready_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_WIDTH{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; valid2 alone is compacted into the tail slot.
  always_ff @(posedge clk) begin
    if (wr1_s) begin
      instr_q[tail_q] <= fetch_instr1_i;
      pc_q[tail_q]    <= fetch_pc1_i;
    end
    if (wr2_s) begin
      instr_q[wr2_idx_s] <= fetch_instr2_i;
      pc_q[wr2_idx_s]    <= fetch_pc2_i;
    end
  end

  assign ins1_valid_o   = (disp_n_s != 2'd0);
  assign ins2_valid_o   = (disp_n_s == 2'd2);
  assign instruction1_o = ins1_valid_o ? instr_q[head_q]  : {INSTR_WIDTH{1'b0}};
  assign PC1_o          = ins1_valid_o ? pc_q[head_q]     : {PC_WIDTH{1'b0}};
  assign instruction2_o = ins2_valid_o ? instr_q[head1_s] : {INSTR_WIDTH{1'b0}};
  assign PC2_o          = ins2_valid_o ? pc_q[head1_s]    : {PC_WIDTH{1'b0}};

  assign fetch_ready_o  = ~rst & ready_s;
  assign occupancy_o    = rst ? {CNT_WIDTH{1'b0}} : count_q;
  assign overflow_err_o = ~rst & overflow_q;

`ifdef DEC_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles with work held but no ROB space.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (count_q != CNT_WIDTH'(0) && rob_free_i == 2'd0 && !flush_i &&
                 stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = rst ? 32'd0 : stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dec_issue_queue.sv
// Directed bench for dec_issue_queue: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_dec_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid1_i, fetch_valid2_i;
  logic [31:0] fetch_instr1_i, fetch_instr2_i, fetch_pc1_i, fetch_pc2_i;
  logic        fetch_ready_o;
  logic [1:0]  rob_free_i;
  logic        flush_i;
  logic [31:0] instruction1_o, instruction2_o, PC1_o, PC2_o;
  logic        ins1_valid_o, ins2_valid_o;
  logic [3:0]  occupancy_o;
  logic        overflow_err_o;
  logic [31:0] stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  dec_issue_queue dut (
    .clk(clk), .rst(rst),
    .fetch_valid1_i(fetch_valid1_i), .fetch_instr1_i(fetch_instr1_i), .fetch_pc1_i(fetch_pc1_i),
    .fetch_valid2_i(fetch_valid2_i), .fetch_instr2_i(fetch_instr2_i), .fetch_pc2_i(fetch_pc2_i),
    .fetch_ready_o(fetch_ready_o), .rob_free_i(rob_free_i), .flush_i(flush_i),
    .instruction1_o(instruction1_o), .ins1_valid_o(ins1_valid_o), .PC1_o(PC1_o),
    .instruction2_o(instruction2_o), .ins2_valid_o(ins2_valid_o), .PC2_o(PC2_o),
    .occupancy_o(occupancy_o), .overflow_err_o(overflow_err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of {instr, pc}, sticky error and stall counter.
  logic [31:0] mq_i[$];
  logic [31:0] mq_p[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_stall = 32'd0;

  always @(negedge clk) begin
    int          cnt, rs, n;
    logic        rdy;
    logic [31:0] h;
    logic [31:0] e_i1, e_i2, e_p1, e_p2, e_st;
    if (rst) begin
      chk("rst_v1", {63'd0, ins1_valid_o}, 64'd0);
      chk("rst_v2", {63'd0, ins2_valid_o}, 64'd0);
      chk("rst_ready", {63'd0, fetch_ready_o}, 64'd0);
      chk("rst_occ", {60'd0, occupancy_o}, 64'd0);
      chk("rst_ovf", {63'd0, overflow_err_o}, 64'd0);
      chk("rst_stall", {32'd0, stall_cnt_o}, 64'd0);
      mq_i.delete();
      mq_p.delete();
      m_ovf   = 1'b0;
      m_stall = 32'd0;
    end else begin
      cnt = mq_i.size();
      rdy = (8 - cnt) >= 2;
      rs  = (rob_free_i == 2'd3) ? 2 : int'(rob_free_i);
      n   = (cnt < rs) ? cnt : rs;
      if (n > 2) n = 2;
      if (cnt > 0) begin
        h = mq_i[0];
        if (n == 2 && h[6:0] == 7'b1100111) n = 1;
      end
      if (flush_i) n = 0;
      e_i1 = (n >= 1) ? mq_i[0] : 32'd0;
      e_p1 = (n >= 1) ? mq_p[0] : 32'd0;
      e_i2 = (n == 2) ? mq_i[1] : 32'd0;
      e_p2 = (n == 2) ? mq_p[1] : 32'd0;
`ifdef DEC_STALL_CNT_EN
      e_st = m_stall;
`else
      e_st = 32'd0;
`endif
      chk("m_v1", {63'd0, ins1_valid_o}, {63'd0, n >= 1});
      chk("m_v2", {63'd0, ins2_valid_o}, {63'd0, n == 2});
      chk("m_i1", {32'd0, instruction1_o}, {32'd0, e_i1});
      chk("m_p1", {32'd0, PC1_o}, {32'd0, e_p1});
      chk("m_i2", {32'd0, instruction2_o}, {32'd0, e_i2});
      chk("m_p2", {32'd0, PC2_o}, {32'd0, e_p2});
      chk("m_occ", {60'd0, occupancy_o}, 64'(cnt));
      chk("m_ready", {63'd0, fetch_ready_o}, {63'd0, rdy});
      chk("m_ovf", {63'd0, overflow_err_o}, {63'd0, m_ovf});
      chk("m_stall", {32'd0, stall_cnt_o}, {32'd0, e_st});
      // Advance the model to the state after the coming edge.
      if (cnt > 0 && rob_free_i == 2'd0 && !flush_i && m_stall != 32'hFFFF_FFFF)
        m_stall = m_stall + 32'd1;
      if ((fetch_valid1_i || fetch_valid2_i) && !rdy) m_ovf = 1'b1;
      if (flush_i) begin
        mq_i.delete();
        mq_p.delete();
      end else begin
        repeat (n) begin
          void'(mq_i.pop_front());
          void'(mq_p.pop_front());
        end
        if (rdy && fetch_valid1_i) begin
          mq_i.push_back(fetch_instr1_i);
          mq_p.push_back(fetch_pc1_i);
        end
        if (rdy && fetch_valid2_i) begin
          mq_i.push_back(fetch_instr2_i);
          mq_p.push_back(fetch_pc2_i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v1, input logic [31:0] i1, input logic [31:0] p1,
                          input logic v2, input logic [31:0] i2, input logic [31:0] p2);
    fetch_valid1_i = v1; fetch_instr1_i = i1; fetch_pc1_i = p1;
    fetch_valid2_i = v2; fetch_instr2_i = i2; fetch_pc2_i = p2;
  endtask

  task automatic no_push();
    set_push(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; rob_free_i = 2'd2;
    set_push(1'b1, 32'h1111_1111, 32'h10, 1'b1, 32'h2222_2222, 32'h14);
    repeat (2) tick();
    rst = 1'b0; no_push();
    #1;
    chk("ready_after_rst", {63'd0, fetch_ready_o}, 64'd1);
    chk("occ_after_rst", {60'd0, occupancy_o}, 64'd0);

    // Basic pair push and dual dispatch.
    set_push(1'b1, 32'h0050_0093, 32'h100, 1'b1, 32'h0020_8133, 32'h104);
    #1;
    chk("no_bypass", {63'd0, ins1_valid_o}, 64'd0);
    tick(); no_push(); #1;
    chk("pair_v1", {63'd0, ins1_valid_o}, 64'd1);
    chk("pair_v2", {63'd0, ins2_valid_o}, 64'd1);
    chk("pair_i1", {32'd0, instruction1_o}, 64'h0050_0093);
    chk("pair_p1", {32'd0, PC1_o}, 64'h100);
    chk("pair_i2", {32'd0, instruction2_o}, 64'h0020_8133);
    chk("pair_p2", {32'd0, PC2_o}, 64'h104);
    chk("pair_occ2", {60'd0, occupancy_o}, 64'd2);
    tick(); #1;
    chk("pair_occ0", {60'd0, occupancy_o}, 64'd0);

    // Fill to full with no ROB space, then overflow.
    rob_free_i = 2'd0;
    for (int k = 0; k < 4; k++) begin
      set_push(1'b1, 32'h0000_0013 | (32'(2*k) << 20), 32'h10 + 32'(8*k),
               1'b1, 32'h0000_0013 | (32'(2*k+1) << 20), 32'h14 + 32'(8*k));
      #1;
      if (k == 3) begin
        chk("ready_at6", {63'd0, fetch_ready_o}, 64'd1);
        chk("occ_at6", {60'd0, occupancy_o}, 64'd6);
      end
      tick();
    end
    #1;
    chk("full_occ", {60'd0, occupancy_o}, 64'd8);
    chk("full_ready", {63'd0, fetch_ready_o}, 64'd0);
    set_push(1'b1, 32'hDEAD_0013, 32'hBAD0, 1'b1, 32'hDEAD_1013, 32'hBAD4);
    tick(); no_push(); #1;
    chk("ovf_set", {63'd0, overflow_err_o}, 64'd1);
    chk("ovf_occ8", {60'd0, occupancy_o}, 64'd8);
    rob_free_i = 2'd1; #1;
    chk("full_head_pc", {32'd0, PC1_o}, 64'h10);
    tick(); rob_free_i = 2'd0; #1;
    chk("occ7", {60'd0, occupancy_o}, 64'd7);
    chk("ready_at7", {63'd0, fetch_ready_o}, 64'd0);
    rob_free_i = 2'd3;
    repeat (4) tick();
    #1;
    chk("drain_occ", {60'd0, occupancy_o}, 64'd0);
    chk("ovf_sticky", {63'd0, overflow_err_o}, 64'd1);

    // Single-issue drain with rob_free=1.
    rob_free_i = 2'd0;
    set_push(1'b1, 32'h0010_0013, 32'h200, 1'b1, 32'h0020_0013, 32'h204); tick();
    set_push(1'b1, 32'h0030_0013, 32'h208, 1'b1, 32'h0040_0013, 32'h20C); tick();
    no_push(); rob_free_i = 2'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("single_v1", {63'd0, ins1_valid_o}, 64'd1);
      chk("single_v2", {63'd0, ins2_valid_o}, 64'd0);
      chk("single_pc", {32'd0, PC1_o}, 64'h200 + 64'(4*k));
      tick();
    end
    #1;
    chk("single_occ0", {60'd0, occupancy_o}, 64'd0);

    // Jump at head serializes dispatch.
    rob_free_i = 2'd0;
    set_push(1'b1, 32'h0000_80E7, 32'h300, 1'b1, 32'h0020_8133, 32'h304); tick();
    no_push(); rob_free_i = 2'd2; #1;
    chk("jmp_v1", {63'd0, ins1_valid_o}, 64'd1);
    chk("jmp_v2", {63'd0, ins2_valid_o}, 64'd0);
    chk("jmp_i1", {32'd0, instruction1_o}, 64'h0000_80E7);
    chk("jmp_i2_zero", {32'd0, instruction2_o}, 64'd0);
    tick(); #1;
    chk("after_jmp_i1", {32'd0, instruction1_o}, 64'h0020_8133);
    chk("after_jmp_p1", {32'd0, PC1_o}, 64'h304);
    chk("after_jmp_v2", {63'd0, ins2_valid_o}, 64'd0);
    tick();

    // Flush with 5 entries and a concurrent push.
    rob_free_i = 2'd0;
    set_push(1'b1, 32'h0000_0033, 32'h500, 1'b1, 32'h0000_00B3, 32'h504); tick();
    set_push(1'b1, 32'h0000_0133, 32'h508, 1'b1, 32'h0000_01B3, 32'h50C); tick();
    set_push(1'b1, 32'h0000_0233, 32'h510, 1'b0, 32'd0, 32'd0); tick();
    rob_free_i = 2'd2; flush_i = 1'b1;
    set_push(1'b1, 32'hAAAA_0013, 32'h600, 1'b1, 32'hBBBB_0013, 32'h604);
    #1;
    chk("flush_occ5", {60'd0, occupancy_o}, 64'd5);
    chk("flush_v1", {63'd0, ins1_valid_o}, 64'd0);
    chk("flush_v2", {63'd0, ins2_valid_o}, 64'd0);
    tick(); flush_i = 1'b0; no_push(); #1;
    chk("post_flush_occ", {60'd0, occupancy_o}, 64'd0);
    chk("post_flush_v1", {63'd0, ins1_valid_o}, 64'd0);
    tick();

    // Reset in the middle of operation.
    rob_free_i = 2'd0;
    set_push(1'b1, 32'h0000_0013, 32'h700, 1'b1, 32'h0000_0013, 32'h704); tick();
    no_push(); rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("midrst_occ", {60'd0, occupancy_o}, 64'd0);
    chk("midrst_ovf", {63'd0, overflow_err_o}, 64'd0);

    // Stall counter; also a valid2-only (compacted) push.
    set_push(1'b1, 32'h0000_0013, 32'h400, 1'b1, 32'h0000_0093, 32'h404); tick();
    set_push(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0113, 32'h408); tick();
    no_push();
    repeat (9) tick();
    #1;
    chk("stall_occ3", {60'd0, occupancy_o}, 64'd3);
`ifdef DEC_STALL_CNT_EN
    chk("stall_cnt", {32'd0, stall_cnt_o}, 64'd10);
`else
    chk("stall_cnt", {32'd0, stall_cnt_o}, 64'd0);
`endif
    rob_free_i = 2'd2; #1;
    chk("compact_p1", {32'd0, PC1_o}, 64'h400);
    tick(); #1;
    chk("compact_p3", {32'd0, PC1_o}, 64'h408);
    chk("compact_v2", {63'd0, ins2_valid_o}, 64'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
